stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_MEM

---
 rtl/stage_mem_pkg.sv | 33 +++
 rtl/stage_mem_dmem.sv | 52 +++++
 rtl/stage_mem.sv | 71 +++++++
 tb/tb_stage_mem.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: access-size encodings, MEM/WB record and byte-lane helper for the MEM stage
package stage_mem_pkg;

    typedef enum logic [1:0] {
        ST_WORD = 2'b00,
        ST_HALF = 2'b01,
        ST_BYTE = 2'b10,
        ST_RSVD = 2'b11
    } store_size_e;

    typedef enum logic [1:0] {
        LD_WORD  = 2'b00,
        LD_HALF  = 2'b01,
        LD_BYTE  = 2'b10,
        LD_BYTEU = 2'b11
    } load_size_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
    } memwb_t;

    // Byte lanes touched by a store; misaligned offsets collapse onto the aligned lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == ST_WORD ? 4'b1111 :
               size == ST_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
               size == ST_BYTE ? 4'b0001 << off : 4'b0000;
    endfunction

endpackage

// File: rtl/stage_mem_dmem.sv
// DataMemory: word-addressed data RAM with byte-lane writes and combinational sized reads
module DataMemory
    import stage_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Store_size,
    input  logic [1:0]  Load_size,
    output logic [31:0] ReadData
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   word;
    logic [15:0]   half;
    logic [7:0]    bsel;
    logic          unused_addr;

    assign idx         = Address[AW+1:2];
    assign unused_addr = ^Address[31:AW+2];

    // Lane enables, replicated store data and the sized, extended read path.
    always_comb begin
        be       = (MemWrite && !Rst) ? lane_mask(Store_size, Address[1:0]) : 4'b0000;
        wdata    = Store_size == ST_WORD ? WriteData :
                   Store_size == ST_HALF ? {2{WriteData[15:0]}} : {4{WriteData[7:0]}};
        word     = mem_q[idx];
        half     = Address[1] ? word[31:16] : word[15:0];
        bsel     = word[{Address[1:0], 3'b000} +: 8];
        ReadData = !MemRead              ? 32'h0 :
                   Load_size == LD_WORD  ? word :
                   Load_size == LD_HALF  ? {{16{half[15]}}, half} :
                   Load_size == LD_BYTE  ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
    end

    // Store only the enabled lanes; contents are never cleared by reset.
    always_ff @(posedge Clk) begin
        for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: MEM pipeline stage -- branch resolve, data memory access and the MEM/WB register
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWrite_in_MEM,
    input  logic        MemtoReg_in_MEM,
    input  logic        Branch_in_MEM,
    input  logic        MemRead_in_MEM,
    input  logic        MemWrite_in_MEM,
    input  logic        Zero_MEM,
    input  logic [31:0] ALUAddResult_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] ReadData2_MEM,
    input  logic [4:0]  WriteReg_in_MEM,
    input  logic [1:0]  Store_size_MEM,
    input  logic [1:0]  Load_size_MEM,
    input  logic        Flush_MEM,
    output logic        PCSrc_MEM,
    output logic [31:0] BranchTarget_MEM,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [31:0] ReadData_WB,
    output logic [31:0] ALUResult_WB,
    output logic [4:0]  WriteReg_WB
);

    logic [31:0] load_data;
    memwb_t      memwb_d;
    memwb_t      memwb_q;

    DataMemory #(.MEM_WORDS(MEM_WORDS)) u_dmem (
        .Clk        (Clk),
        .Rst        (Rst),
        .Address    (ALUResult_MEM),
        .WriteData  (ReadData2_MEM),
        .MemWrite   (MemWrite_in_MEM),
        .MemRead    (MemRead_in_MEM),
        .Store_size (Store_size_MEM),
        .Load_size  (Load_size_MEM),
        .ReadData   (load_data)
    );

    assign PCSrc_MEM        = Branch_in_MEM & Zero_MEM;
    assign BranchTarget_MEM = ALUAddResult_MEM;

    // Next MEM/WB contents; a flush kills only the write-back controls.
    always_comb begin
        memwb_d.reg_write  = RegWrite_in_MEM && !Flush_MEM;
        memwb_d.mem_to_reg = MemtoReg_in_MEM && !Flush_MEM;
        memwb_d.read_data  = load_data;
        memwb_d.alu_result = ALUResult_MEM;
        memwb_d.write_reg  = WriteReg_in_MEM;
    end

    // MEM/WB pipeline register, cleared asynchronously.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) memwb_q <= '0;
        else     memwb_q <= memwb_d;
    end

    assign RegWrite_WB  = memwb_q.reg_write;
    assign MemtoReg_WB  = memwb_q.mem_to_reg;
    assign ReadData_WB  = memwb_q.read_data;
    assign ALUResult_WB = memwb_q.alu_result;
    assign WriteReg_WB  = memwb_q.write_reg;

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed scoreboard bench for the MEM stage
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        RegWrite_in_MEM = 1'b0;
    logic        MemtoReg_in_MEM = 1'b0;
    logic        Branch_in_MEM = 1'b0;
    logic        MemRead_in_MEM = 1'b0;
    logic        MemWrite_in_MEM = 1'b0;
    logic        Zero_MEM = 1'b0;
    logic [31:0] ALUAddResult_MEM = 32'h0;
    logic [31:0] ALUResult_MEM = 32'h0;
    logic [31:0] ReadData2_MEM = 32'h0;
    logic [4:0]  WriteReg_in_MEM = 5'h0;
    logic [1:0]  Store_size_MEM = 2'b00;
    logic [1:0]  Load_size_MEM = 2'b00;
    logic        Flush_MEM = 1'b0;
    logic        PCSrc_MEM;
    logic [31:0] BranchTarget_MEM;
    logic        RegWrite_WB;
    logic        MemtoReg_WB;
    logic [31:0] ReadData_WB;
    logic [31:0] ALUResult_WB;
    logic [4:0]  WriteReg_WB;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        rw;
        logic        mtr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    stage_mem #(.MEM_WORDS(1024)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .RegWrite_in_MEM  (RegWrite_in_MEM),
        .MemtoReg_in_MEM  (MemtoReg_in_MEM),
        .Branch_in_MEM    (Branch_in_MEM),
        .MemRead_in_MEM   (MemRead_in_MEM),
        .MemWrite_in_MEM  (MemWrite_in_MEM),
        .Zero_MEM         (Zero_MEM),
        .ALUAddResult_MEM (ALUAddResult_MEM),
        .ALUResult_MEM    (ALUResult_MEM),
        .ReadData2_MEM    (ReadData2_MEM),
        .WriteReg_in_MEM  (WriteReg_in_MEM),
        .Store_size_MEM   (Store_size_MEM),
        .Load_size_MEM    (Load_size_MEM),
        .Flush_MEM        (Flush_MEM),
        .PCSrc_MEM        (PCSrc_MEM),
        .BranchTarget_MEM (BranchTarget_MEM),
        .RegWrite_WB      (RegWrite_WB),
        .MemtoReg_WB      (MemtoReg_WB),
        .ReadData_WB      (ReadData_WB),
        .ALUResult_WB     (ALUResult_WB),
        .WriteReg_WB      (WriteReg_WB)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_zero(input string tag);
        chk({tag, ".rw"},   {31'h0, RegWrite_WB}, 32'h0);
        chk({tag, ".mtr"},  {31'h0, MemtoReg_WB}, 32'h0);
        chk({tag, ".rd"},   ReadData_WB, 32'h0);
        chk({tag, ".alu"},  ALUResult_WB, 32'h0);
        chk({tag, ".wreg"}, {27'h0, WriteReg_WB}, 32'h0);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".rd"},   ReadData_WB, e.rd);
        chk({tag, ".alu"},  ALUResult_WB, e.alu);
        chk({tag, ".wreg"}, {27'h0, WriteReg_WB}, {27'h0, e.wreg});
        chk({tag, ".rw"},   {31'h0, RegWrite_WB}, {31'h0, e.rw});
        chk({tag, ".mtr"},  {31'h0, MemtoReg_WB}, {31'h0, e.mtr});
    endtask

    // Drive one instruction into MEM; the write-back controls follow rw and are killed by a flush.
    task automatic op(input string tag, input logic mr, input logic mw, input logic [1:0] ss,
                      input logic [1:0] ls, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rw, input logic fl, input logic [4:0] wreg,
                      input logic [31:0] exp_rd);
        MemRead_in_MEM  = mr;
        MemWrite_in_MEM = mw;
        Store_size_MEM  = ss;
        Load_size_MEM   = ls;
        ALUResult_MEM   = addr;
        ReadData2_MEM   = wd;
        RegWrite_in_MEM = rw;
        MemtoReg_in_MEM = rw;
        Flush_MEM       = fl;
        WriteReg_in_MEM = wreg;
        sb.push_back('{rd: exp_rd, alu: addr, wreg: wreg, rw: rw & ~fl, mtr: rw & ~fl});
        tick(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #1 Rst = 1'b1;
        #2 wb_zero("por");
        @(posedge Clk);
        #1 wb_zero("por_edge");
        Rst = 1'b0;
        op("init_10",  0, 1, ST_WORD, LD_WORD, 32'h10,   32'h0,        0, 0, 5'd1, 32'h0);
        op("init_20",  0, 1, ST_WORD, LD_WORD, 32'h20,   32'hAAAAAAAA, 0, 0, 5'd1, 32'h0);
        op("sw_dead",  0, 1, ST_WORD, LD_WORD, 32'h10,   32'hDEADBEEF, 0, 0, 5'd2, 32'h0);
        op("lw_dead",  1, 0, ST_WORD, LD_WORD, 32'h10,   32'h0,        1, 0, 5'd3, 32'hDEADBEEF);
        op("rd_wr",    1, 1, ST_WORD, LD_WORD, 32'h10,   32'h0,        1, 0, 5'd4, 32'hDEADBEEF);
        op("sb_80",    0, 1, ST_BYTE, LD_WORD, 32'h13,   32'hFFFFFF80, 0, 0, 5'd4, 32'h0);
        op("lb_13",    1, 0, ST_WORD, LD_BYTE, 32'h13,   32'h0,        1, 0, 5'd6, 32'hFFFFFF80);
        op("lbu_13",   1, 0, ST_WORD, LD_BYTEU,32'h13,   32'h0,        1, 0, 5'd6, 32'h00000080);
        op("lw_10",    1, 0, ST_WORD, LD_WORD, 32'h10,   32'h0,        1, 0, 5'd6, 32'h80000000);
        op("sh_1234",  0, 1, ST_HALF, LD_WORD, 32'h22,   32'hFFFF1234, 0, 0, 5'd8, 32'h0);
        op("lh_22",    1, 0, ST_WORD, LD_HALF, 32'h22,   32'h0,        1, 0, 5'd9, 32'h00001234);
        op("lw_20",    1, 0, ST_WORD, LD_WORD, 32'h20,   32'h0,        1, 0, 5'd9, 32'h1234AAAA);
        op("lh_23",    1, 0, ST_WORD, LD_HALF, 32'h23,   32'h0,        1, 0, 5'd9, 32'h00001234);
        op("lh_20",    1, 0, ST_WORD, LD_HALF, 32'h20,   32'h0,        1, 0, 5'd9, 32'hFFFFAAAA);
        op("st_rsvd",  1, 1, ST_RSVD, LD_WORD, 32'h20,   32'hFFFFFFFF, 1, 0, 5'd10, 32'h1234AAAA);
        op("lw_rsvd",  1, 0, ST_WORD, LD_WORD, 32'h20,   32'h0,        1, 0, 5'd10, 32'h1234AAAA);
        op("sw_wrap",  0, 1, ST_WORD, LD_WORD, 32'h1030, 32'h00000055, 0, 0, 5'd11, 32'h0);
        op("lw_mis",   1, 0, ST_WORD, LD_WORD, 32'h33,   32'h0,        1, 0, 5'd12, 32'h00000055);
        op("lb_30",    1, 0, ST_WORD, LD_BYTE, 32'h30,   32'h0,        1, 0, 5'd12, 32'h00000055);
        op("lbu_31",   1, 0, ST_WORD, LD_BYTEU,32'h31,   32'h0,        1, 0, 5'd12, 32'h0);
        Branch_in_MEM = 1'b1;
        Zero_MEM = 1'b1;
        ALUAddResult_MEM = 32'h40;
        #1 chk("br_taken", {31'h0, PCSrc_MEM}, 32'h1);
        chk("br_target", BranchTarget_MEM, 32'h40);
        Zero_MEM = 1'b0;
        #1 chk("br_nz", {31'h0, PCSrc_MEM}, 32'h0);
        Branch_in_MEM = 1'b0;
        Zero_MEM = 1'b1;
        #1 chk("br_nobr", {31'h0, PCSrc_MEM}, 32'h0);
        Zero_MEM = 1'b0;
        op("flush_sw", 0, 1, ST_WORD, LD_WORD, 32'h40,   32'h0BADF00D, 1, 1, 5'd5, 32'h0);
        op("lw_40",    1, 0, ST_WORD, LD_WORD, 32'h40,   32'h0,        1, 0, 5'd7, 32'h0BADF00D);
        #2 Rst = 1'b1;
        #1 wb_zero("rst_mid");
        MemRead_in_MEM  = 1'b0;
        MemWrite_in_MEM = 1'b1;
        Store_size_MEM  = ST_WORD;
        ALUResult_MEM   = 32'h40;
        ReadData2_MEM   = 32'hFFFFFFFF;
        RegWrite_in_MEM = 1'b1;
        @(posedge Clk);
        #1 wb_zero("rst_edge");
        Rst = 1'b0;
        op("lw_post",  1, 0, ST_WORD, LD_WORD, 32'h40,   32'h0,        1, 0, 5'd13, 32'h0BADF00D);
        op("lw_keep",  1, 0, ST_WORD, LD_WORD, 32'h10,   32'h0,        1, 0, 5'd14, 32'h80000000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
